// File: rtl/fetch_mem_ctrl.sv
// fetch_mem_ctrl
//   Instruction fetch sequencer between the program counter / IF-ID register
//   and an instruction memory with a variable-latency req/ack bus. Handles
//   decode stalls and branch/jump redirects, including redirects that arrive
//   while a fetch is still outstanding (the late response is squashed).
//
// Ports
//   i_CLK, i_RST          clock, synchronous active-high reset
//   i_PCF                 current PC
//   i_Redirect            branch/jump taken; PC loads its target at this edge
//   i_StallD              decode stall
//   o_StallF              hold PC (active-high)
//   o_MemReq, o_MemAddr   fetch request / address (from state and addr_q only)
//   i_MemAck, i_MemRData  response strobe / instruction word
//   o_InstrF              instruction to IF/ID, NOP_INSTR when not valid
//   o_InstrValidF         o_InstrF carries a real instruction
//   o_FetchErr            sticky watchdog timeout
//
// Build option
//   FETCH_PERF_CNT_EN     adds o_StallCycles (cycles with o_StallF=1) and
//                         o_SquashCount (dropped acks); both saturate.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ISSUE | idle between fetches; latch i_PCF unless a redirect is live
// ST_WAIT  | request outstanding on the bus, waiting for i_MemAck
// ST_HOLD  | instruction received under decode stall, replayed from instr_q
module fetch_mem_ctrl #(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter int                     INSTR_WIDTH   = 32,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR     = '0,
  parameter int                     MAX_WAIT      = 64
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [ADDRESS_WIDTH-1:0] i_PCF,
  input  logic                     i_Redirect,
  input  logic                     i_StallD,
  output logic                     o_StallF,
  output logic                     o_MemReq,
  output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
  input  logic                     i_MemAck,
  input  logic [INSTR_WIDTH-1:0]   i_MemRData,
  output logic [INSTR_WIDTH-1:0]   o_InstrF,
  output logic                     o_InstrValidF,
  output logic                     o_FetchErr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              o_StallCycles,
  output logic [15:0]              o_SquashCount
`endif
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD} state_t;

  state_t                   state;
  logic                     squash;
  logic [CW-1:0]            wait_cnt;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [INSTR_WIDTH-1:0]   instr_q;

  logic accept;
  logic drop;
  logic wd_hit;

  // An ack is only taken when it belongs to the current PC: a squash marks a
  // request whose PC was redirected away, and a same-cycle redirect kills it too.
  assign accept = (state == ST_WAIT) & i_MemAck & ~squash & ~i_Redirect;
  assign drop   = (state == ST_WAIT) & i_MemAck & (squash | i_Redirect);
  assign wd_hit = (MAX_WAIT != 0) && (wait_cnt == WD_LAST);

  assign o_MemReq  = (state == ST_WAIT);
  assign o_MemAddr = addr_q;

  always_comb begin
    // A redirect always releases the PC so it can load the target.
    o_StallF      = ~i_Redirect;
    o_InstrF      = NOP_INSTR;
    o_InstrValidF = 1'b0;
    case (state)
      ST_WAIT: begin
        if (accept) begin
          o_InstrF      = i_MemRData;
          o_InstrValidF = 1'b1;
          o_StallF      = i_StallD;
        end
      end
      ST_HOLD: begin
        if (!i_Redirect) begin
          o_InstrF      = instr_q;
          o_InstrValidF = 1'b1;
          o_StallF      = i_StallD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= ST_ISSUE;
      squash     <= 1'b0;
      wait_cnt   <= '0;
      addr_q     <= '0;
      instr_q    <= NOP_INSTR;
      o_FetchErr <= 1'b0;
    end else begin
      case (state)
        ST_ISSUE: begin
          // On a redirect the PC only holds the target after this edge.
          if (!i_Redirect) begin
            addr_q   <= i_PCF;
            wait_cnt <= '0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_MemAck) begin
            squash <= 1'b0;
            if (accept && i_StallD) begin
              instr_q <= i_MemRData;
              state   <= ST_HOLD;
            end else begin
              state <= ST_ISSUE;
            end
          end else begin
            // The bus cannot cancel a request, so a redirect just marks the
            // in-flight response for discard and keeps waiting for it.
            if (i_Redirect) squash <= 1'b1;
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 1'b1;
            if (wd_hit) o_FetchErr <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (i_Redirect || !i_StallD) state <= ST_ISSUE;
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_StallCycles <= '0;
      o_SquashCount <= '0;
    end else begin
      if (o_StallF && (o_StallCycles != '1)) o_StallCycles <= o_StallCycles + 32'd1;
      if (drop && (o_SquashCount != '1))     o_SquashCount <= o_SquashCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_mem_ctrl.sv
// Directed bench for fetch_mem_ctrl. Stimulus pushes per-cycle expectations
// and expected request addresses into queues; a negedge monitor pops them.
module tb_fetch_mem_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          X   = -1;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcf;
  logic        redir;
  logic        stall_d;
  logic        ack;
  logic [31:0] rdata;
  logic        stall_f;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instr_f;
  logic        valid_f;
  logic        fetch_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] squash_count;
`endif

  fetch_mem_ctrl #(
    .ADDRESS_WIDTH(32),
    .INSTR_WIDTH  (32),
    .NOP_INSTR    (NOP),
    .MAX_WAIT     (4)
  ) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_PCF        (pcf),
    .i_Redirect   (redir),
    .i_StallD     (stall_d),
    .o_StallF     (stall_f),
    .o_MemReq     (mem_req),
    .o_MemAddr    (mem_addr),
    .i_MemAck     (ack),
    .i_MemRData   (rdata),
    .o_InstrF     (instr_f),
    .o_InstrValidF(valid_f),
    .o_FetchErr   (fetch_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .o_StallCycles(stall_cycles),
    .o_SquashCount(squash_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          es;
    int          ev;
    logic [31:0] ei;
    int          eq;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  string       tag   = "init";
  logic        req_d = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle outputs plus the address of every new request.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.es >= 0) cmp({e.tag, " stall_f"}, 32'(stall_f), 32'(e.es));
      if (e.ev >= 0) begin
        cmp({e.tag, " valid_f"}, 32'(valid_f), 32'(e.ev));
        cmp({e.tag, " instr_f"}, instr_f, e.ei);
      end
      if (e.eq >= 0) cmp({e.tag, " mem_req"}, 32'(mem_req), 32'(e.eq));
    end
    if (mem_req === 1'b1 && !req_d) begin
      if (addr_q.size() == 0) cmp("unexpected request addr", mem_addr, 32'hFFFF_FFFF);
      else                    cmp("request addr", mem_addr, addr_q.pop_front());
    end
    req_d <= (mem_req === 1'b1);
  end

  // One clock cycle: drive inputs after the edge, record what this cycle must show.
  task automatic cyc(input logic [31:0] pc, input logic r, input logic s, input logic a,
                     input logic [31:0] d, input int es, input int ev,
                     input logic [31:0] ei, input int eq);
    exp_t e;
    pcf = pc; redir = r; stall_d = s; ack = a; rdata = d;
    e.es = es; e.ev = ev; e.ei = ei; e.eq = eq; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // ISSUE cycle without redirect: next cycle starts a request at pc.
  task automatic issue(input logic [31:0] pc);
    addr_q.push_back(pc);
    cyc(pc, 0, 0, 0, 32'h0, 1, 0, NOP, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pcf = '0; redir = 1'b0; stall_d = 1'b0; ack = 1'b0; rdata = '0;
    @(posedge clk); #1;

    tag = "reset";
    cyc(32'h0, 0, 0, 0, 32'h0, 1, 0, NOP, 0);
    cyc(32'h0, 0, 0, 0, 32'h0, 1, 0, NOP, 0);
    cmp("reset fetch_err", 32'(fetch_err), 32'd0);
    rst = 1'b0;

    tag = "ack1";
    for (int i = 0; i < 3; i++) begin
      issue(32'(i * 4));
      cyc(32'(i * 4), 0, 0, 1, mem_word(32'(i * 4)), 0, 1, mem_word(32'(i * 4)), 1);
    end

    tag = "hold";
    issue(32'h0C);
    cyc(32'h0C, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cyc(32'h0C, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cyc(32'h0C, 0, 1, 1, mem_word(32'h0C), 1, 1, mem_word(32'h0C), 1);
    cyc(32'h0C, 0, 1, 0, 32'h0,            1, 1, mem_word(32'h0C), 0);
    cyc(32'h0C, 0, 0, 0, 32'h0,            0, 1, mem_word(32'h0C), 0);

    tag = "squash";
    issue(32'h10);
    cyc(32'h10, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cyc(32'h10, 1, 0, 0, 32'h0, 0, 0, NOP, 1);
    cyc(32'h40, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cyc(32'h40, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, NOP, 1);
    cmp("squash ack at wd boundary fetch_err", 32'(fetch_err), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    cmp("squash_count after squash", 32'(squash_count), 32'd1);
`endif
    issue(32'h40);
    cyc(32'h40, 0, 0, 1, mem_word(32'h40), 0, 1, mem_word(32'h40), 1);

    tag = "redir_ack";
    issue(32'h44);
    cyc(32'h44, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cyc(32'h44, 1, 0, 1, 32'hBAD0_0044, 0, 0, NOP, 1);
`ifdef FETCH_PERF_CNT_EN
    cmp("squash_count after redirect+ack", 32'(squash_count), 32'd2);
`endif
    issue(32'h80);
    cyc(32'h80, 0, 0, 1, mem_word(32'h80), 0, 1, mem_word(32'h80), 1);

    tag = "redir_issue_hold";
    cyc(32'h84, 1, 0, 0, 32'h0, 0, 0, NOP, 0);
    issue(32'h100);
    cyc(32'h100, 0, 1, 1, mem_word(32'h100), 1, 1, mem_word(32'h100), 1);
    cyc(32'h100, 1, 1, 0, 32'h0, 0, 0, NOP, 0);

    tag = "watchdog";
    issue(32'h200);
    for (int i = 0; i < 3; i++) cyc(32'h200, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cmp("fetch_err after 3 waits", 32'(fetch_err), 32'd0);
    cyc(32'h200, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cmp("fetch_err after 4 waits", 32'(fetch_err), 32'd1);
    cyc(32'h200, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cyc(32'h200, 0, 0, 0, 32'h0, 1, 0, NOP, 1);
    cmp("fetch_err sticky", 32'(fetch_err), 32'd1);

    tag = "reset_in_wait";
    rst = 1'b1;
    cyc(32'h300, 0, 0, 0, 32'h0, X, X, NOP, 1);
    cmp("fetch_err cleared by reset", 32'(fetch_err), 32'd0);
    rst = 1'b0;
    addr_q.push_back(32'h300);
    cyc(32'h300, 0, 0, 1, 32'hBAD0_0300, 1, 0, NOP, 0);
    cyc(32'h300, 0, 0, 1, mem_word(32'h300), 0, 1, mem_word(32'h300), 1);

    tag = "end";
    rst = 1'b1;
    cyc(32'h0, 0, 0, 0, 32'h0, X, X, NOP, X);
    cyc(32'h0, 0, 0, 0, 32'h0, 1, 0, NOP, 0);
    @(negedge clk); #1;
    cmp("leftover expectations", 32'(exp_q.size()), 32'd0);
    cmp("leftover request addrs", 32'(addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
